// File: rtl/i2c_cmd_queue_if.sv
// Bus between the slow-control register file, the command queue and the I2C master core.
// Optional statistics ports exist only when I2C_CMD_QUEUE_STATS_EN is defined.
interface i2c_cmd_queue_if #(
    parameter int MAX_TX = 7,
    parameter int MAX_RX = 31,
    parameter int DEPTH  = 4
);
    localparam int TXW = $clog2(MAX_TX + 1);
    localparam int RXW = $clog2(MAX_RX + 1);
    localparam int LW  = $clog2(DEPTH + 1);

    // Push side (register file)
    logic                    WR_EN;
    logic [6:0]              SL_ADDR;
    logic [8*MAX_TX-1:0]     TX_DATA;
    logic [TXW-1:0]          NUM_TX;
    logic [RXW-1:0]          NUM_RX;
    logic                    REP_START_IN;
    logic                    FLUSH;
    logic                    ERR_CLR;
    logic                    WR_FULL;
    logic [LW-1:0]           LEVEL;
    logic                    ERR_OVF;
    logic                    ERR_LEN;

    // Pop side (I2C master core)
    logic                    CMD_VALID;
    logic                    CMD_READY;
    logic [8*(MAX_TX+2)-1:0] DATA_FROM_CORE;
    logic [TXW-1:0]          NUM_BYTES_TO_TRANSM_OUT;
    logic [RXW-1:0]          NUM_BYTES_TO_REC_OUT;
    logic                    REP_START_OUT;
    logic                    RW;

`ifdef I2C_CMD_QUEUE_STATS_EN
    logic [15:0]             TX_CMD_CNT;
    logic [7:0]              DROP_CNT;
`endif

    modport master (
        output WR_EN, SL_ADDR, TX_DATA, NUM_TX, NUM_RX, REP_START_IN, FLUSH, ERR_CLR, CMD_READY,
        input  WR_FULL, LEVEL, ERR_OVF, ERR_LEN, CMD_VALID, DATA_FROM_CORE,
               NUM_BYTES_TO_TRANSM_OUT, NUM_BYTES_TO_REC_OUT, REP_START_OUT, RW
`ifdef I2C_CMD_QUEUE_STATS_EN
        , input TX_CMD_CNT, DROP_CNT
`endif
    );

    modport slave (
        input  WR_EN, SL_ADDR, TX_DATA, NUM_TX, NUM_RX, REP_START_IN, FLUSH, ERR_CLR, CMD_READY,
        output WR_FULL, LEVEL, ERR_OVF, ERR_LEN, CMD_VALID, DATA_FROM_CORE,
               NUM_BYTES_TO_TRANSM_OUT, NUM_BYTES_TO_REC_OUT, REP_START_OUT, RW
`ifdef I2C_CMD_QUEUE_STATS_EN
        , output TX_CMD_CNT, DROP_CNT
`endif
    );
endinterface

// File: rtl/i2c_cmd_queue.sv
// DEPTH-entry FIFO of complete I2C commands with first-word fall-through head formatting.
// Define I2C_CMD_QUEUE_STATS_EN to add the TX_CMD_CNT / DROP_CNT statistics counters.
module i2c_cmd_queue #(
    parameter int MAX_TX = 7,
    parameter int MAX_RX = 31,
    parameter int DEPTH  = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    i2c_cmd_queue_if.slave    bus
);
    localparam int TXW = $clog2(MAX_TX + 1);
    localparam int RXW = $clog2(MAX_RX + 1);
    localparam int LW  = $clog2(DEPTH + 1);
    localparam int PW  = $clog2(DEPTH);
    localparam int IW  = 8 * (MAX_TX + 2);

    typedef struct packed {
        logic [6:0]          addr;
        logic [8*MAX_TX-1:0] data;
        logic [TXW-1:0]      num_tx;
        logic [RXW-1:0]      num_rx;
        logic                rep_start;
    } cmd_t;

    cmd_t          slot_q [DEPTH];
    cmd_t          new_cmd;
    cmd_t          head;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          err_ovf_q, err_ovf_d;
    logic          err_len_q, err_len_d;
    logic          full, valid, len_bad, push_req, push, pop, ovf_set, len_set, rw;
    logic [IW-1:0] image;

    // NOTE: every signal written here gets its default first, so no path leaves it
    // holding a previous value and no latch is inferred.
    always_comb begin
        full     = (int'(level_q) == DEPTH);
        valid    = (level_q != '0);
        len_bad  = (int'(bus.NUM_TX) > MAX_TX) || (int'(bus.NUM_RX) > MAX_RX);
        push_req = bus.WR_EN && !bus.FLUSH;
        push     = push_req && !full && !len_bad;
        pop      = valid && bus.CMD_READY && !bus.FLUSH;
        // Overflow is judged on the pre-edge level, so a same-cycle pop cannot rescue a push.
        ovf_set  = push_req && full;
        len_set  = push_req && len_bad;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (bus.FLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end

        err_ovf_d = ovf_set || (err_ovf_q && !bus.ERR_CLR);
        err_len_d = len_set || (err_len_q && !bus.ERR_CLR);

        new_cmd.addr      = bus.SL_ADDR;
        new_cmd.data      = bus.TX_DATA;
        new_cmd.num_tx    = bus.NUM_TX;
        new_cmd.num_rx    = bus.NUM_RX;
        new_cmd.rep_start = bus.REP_START_IN;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            err_ovf_q <= 1'b0;
            err_len_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            err_ovf_q <= err_ovf_d;
            err_len_q <= err_len_d;
        end
    end

    // NOTE: command storage is deliberately not reset; an empty queue masks it at the outputs.
    always_ff @(posedge CLK) begin
        if (push) slot_q[wr_ptr_q] <= new_cmd;
    end

    // Serialiser image: address byte, payload, then the optional repeated-start address byte.
    always_comb begin
        head  = valid ? slot_q[rd_ptr_q] : '0;
        rw    = |head.num_rx;
        image = '0;
        image[7:0] = {head.addr, rw & ~head.rep_start};
        for (int i = 0; i < MAX_TX; i++) begin
            if (i < int'(head.num_tx)) image[8*(i+1) +: 8] = head.data[8*i +: 8];
        end
        if (head.rep_start) begin
            for (int j = 1; j <= MAX_TX + 1; j++) begin
                if (j == int'(head.num_tx) + 1) image[8*j +: 8] = {head.addr, rw};
            end
        end
    end

    assign bus.WR_FULL                 = full;
    assign bus.LEVEL                   = level_q;
    assign bus.CMD_VALID               = valid;
    assign bus.DATA_FROM_CORE          = image;
    assign bus.NUM_BYTES_TO_TRANSM_OUT = head.num_tx;
    assign bus.NUM_BYTES_TO_REC_OUT    = head.num_rx;
    assign bus.REP_START_OUT           = head.rep_start;
    assign bus.RW                      = rw;
    assign bus.ERR_OVF                 = err_ovf_q;
    assign bus.ERR_LEN                 = err_len_q;

`ifdef I2C_CMD_QUEUE_STATS_EN
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;

    // A clear and a same-cycle event leave the counter at the count of that one event.
    always_comb begin
        tx_cnt_d   = bus.ERR_CLR ? '0 : tx_cnt_q;
        drop_cnt_d = bus.ERR_CLR ? '0 : drop_cnt_q;
        if (pop) tx_cnt_d = tx_cnt_d + 16'd1;
        if ((ovf_set || len_set) && drop_cnt_d != 8'hFF) drop_cnt_d = drop_cnt_d + 8'd1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            tx_cnt_q   <= tx_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.TX_CMD_CNT = tx_cnt_q;
    assign bus.DROP_CNT   = drop_cnt_q;
`endif
endmodule

// File: tb/tb_i2c_cmd_queue.sv
// Self-checking bench for i2c_cmd_queue: directed plan plus random traffic against a queue model.
// MAX_RX is reduced to 20 so that a length violation is representable on the NUM_RX port.
module tb_i2c_cmd_queue;
    localparam int MAX_TX = 7;
    localparam int MAX_RX = 20;
    localparam int DEPTH  = 4;

    logic CLK;
    logic RST_N;
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    i2c_cmd_queue_if #(.MAX_TX(MAX_TX), .MAX_RX(MAX_RX), .DEPTH(DEPTH)) bus ();
    i2c_cmd_queue_if #(.MAX_TX(5), .MAX_RX(31), .DEPTH(2)) bus2 ();

    i2c_cmd_queue #(.MAX_TX(MAX_TX), .MAX_RX(MAX_RX), .DEPTH(DEPTH)) u_dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    // Narrow instance: with MAX_TX=5 a payload-length violation fits in NUM_TX.
    i2c_cmd_queue #(.MAX_TX(5), .MAX_RX(31), .DEPTH(2)) u_dut2 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus2)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    typedef struct {
        logic [6:0]  addr;
        logic [55:0] data;
        int          ntx;
        int          nrx;
        bit          rs;
    } ent_t;

    ent_t mq[$];
    bit   m_ovf, m_len;
    int   m_tx, m_drop;

    task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] image_of(ent_t e);
        logic [71:0] r;
        bit rw;
        r  = '0;
        rw = (e.nrx != 0);
        r[7:0] = {e.addr, rw & ~e.rs};
        for (int k = 0; k < e.ntx; k++) r[8*(k+1) +: 8] = e.data[8*k +: 8];
        if (e.rs) r[8*(e.ntx+1) +: 8] = {e.addr, rw};
        return r;
    endfunction

    task automatic check_all(string tag);
        ent_t h;
        bit   v;
        v = (mq.size() != 0);
        if (v) h = mq[0];
        check({tag, ".level"}, bus.LEVEL, mq.size());
        check({tag, ".full"},  bus.WR_FULL, mq.size() == DEPTH);
        check({tag, ".valid"}, bus.CMD_VALID, v);
        check({tag, ".image"}, bus.DATA_FROM_CORE, v ? image_of(h) : 72'h0);
        check({tag, ".ntx"},   bus.NUM_BYTES_TO_TRANSM_OUT, v ? h.ntx : 0);
        check({tag, ".nrx"},   bus.NUM_BYTES_TO_REC_OUT, v ? h.nrx : 0);
        check({tag, ".rs"},    bus.REP_START_OUT, v ? h.rs : 1'b0);
        check({tag, ".rw"},    bus.RW, v ? (h.nrx != 0) : 1'b0);
        check({tag, ".ovf"},   bus.ERR_OVF, m_ovf);
        check({tag, ".len"},   bus.ERR_LEN, m_len);
`ifdef I2C_CMD_QUEUE_STATS_EN
        check({tag, ".txcnt"}, bus.TX_CMD_CNT, m_tx);
        check({tag, ".drop"},  bus.DROP_CNT, m_drop);
`endif
    endtask

    task automatic drive(bit wr, logic [6:0] a, logic [55:0] d, int ntx, int nrx, bit rs,
                         bit rdy, bit fl, bit clr);
        bus.WR_EN        = wr;
        bus.SL_ADDR      = a;
        bus.TX_DATA      = d;
        bus.NUM_TX       = 3'(ntx);
        bus.NUM_RX       = 5'(nrx);
        bus.REP_START_IN = rs;
        bus.CMD_READY    = rdy;
        bus.FLUSH        = fl;
        bus.ERR_CLR      = clr;
    endtask

    task automatic idle(bit rdy);
        drive(1'b0, 7'h0, 56'h0, 0, 0, 1'b0, rdy, 1'b0, 1'b0);
    endtask

    // One clock: the model applies the queue rules to the inputs present at the edge.
    task automatic cycle(string tag);
        bit   full, lbad, wr, push, pop, rej, clr, fl;
        ent_t e;
        full = (mq.size() == DEPTH);
        fl   = bus.FLUSH;
        clr  = bus.ERR_CLR;
        wr   = bus.WR_EN && !fl;
        lbad = (int'(bus.NUM_TX) > MAX_TX) || (int'(bus.NUM_RX) > MAX_RX);
        push = wr && !full && !lbad;
        pop  = (mq.size() != 0) && bus.CMD_READY && !fl;
        rej  = wr && (full || lbad);
        e.addr = bus.SL_ADDR;
        e.data = bus.TX_DATA;
        e.ntx  = int'(bus.NUM_TX);
        e.nrx  = int'(bus.NUM_RX);
        e.rs   = bus.REP_START_IN;
        @(posedge CLK);
        if (fl) mq.delete();
        else begin
            if (pop)  mq.delete(0);
            if (push) mq.push_back(e);
        end
        m_ovf  = (wr && full) || (m_ovf && !clr);
        m_len  = (wr && lbad) || (m_len && !clr);
        m_tx   = ((clr ? 0 : m_tx) + (pop ? 1 : 0)) % 65536;
        m_drop = clr ? 0 : m_drop;
        if (rej && m_drop < 255) m_drop++;
        #1;
        check_all(tag);
    endtask

    initial begin
        RST_N = 1'b0;
        m_ovf = 0; m_len = 0; m_tx = 0; m_drop = 0;
        idle(1'b0);
        bus2.WR_EN = 0; bus2.SL_ADDR = 0; bus2.TX_DATA = 0; bus2.NUM_TX = 0; bus2.NUM_RX = 0;
        bus2.REP_START_IN = 0; bus2.FLUSH = 0; bus2.ERR_CLR = 0; bus2.CMD_READY = 0;
        repeat (2) @(negedge CLK);
        check_all("reset");
        check("reset2.level", bus2.LEVEL, 0);
        RST_N = 1'b1;

        // Plain write, held while the core is not ready.
        drive(1, 7'h50, 56'hBBAA, 2, 0, 0, 0, 0, 0);
        cycle("tp1.push");
        check("tp1.bytes", bus.DATA_FROM_CORE[31:0], 32'h00BBAAA0);
        idle(1'b0);
        repeat (3) cycle("tp1.hold");
        idle(1'b1);
        cycle("tp1.pop");

        // Write then repeated-start read.
        drive(1, 7'h50, 56'h10, 1, 4, 1, 0, 0, 0);
        cycle("tp2.push");
        check("tp2.bytes", bus.DATA_FROM_CORE[23:0], 24'hA110A0);
        check("tp2.rw", bus.RW, 1'b1);
        idle(1'b1);
        cycle("tp2.pop");

        // Full-length payload still leaves room for the repeated-start byte.
        drive(1, 7'h50, 56'h77665544332211, 7, 1, 1, 0, 0, 0);
        cycle("tp3.push");
        check("tp3.bytes", bus.DATA_FROM_CORE, {8'hA1, 56'h77665544332211, 8'hA0});
        idle(1'b1);
        cycle("tp3.pop");

        // Overflow: five pushes into a four-deep queue.
        for (int i = 0; i < 5; i++) begin
            drive(1, 7'(8'h20 + i), 56'(i * 32'h01010101), i + 1, i, i[0], 0, 0, 0);
            cycle("tp4.fill");
            if (i == 3) check("tp4.full", bus.WR_FULL, 1'b1);
        end
        check("tp4.ovf", bus.ERR_OVF, 1'b1);
        check("tp4.level", bus.LEVEL, 4);
`ifdef I2C_CMD_QUEUE_STATS_EN
        check("tp4.drop", bus.DROP_CNT, 1);
`endif
        idle(1'b1);
        repeat (4) cycle("tp4.drain");
        check("tp4.empty", bus.CMD_VALID, 1'b0);

        // Length violation, then clear; a clear colliding with a new error keeps the flag.
        drive(1, 7'h33, 56'h1, 1, 25, 0, 0, 0, 0);
        cycle("tp5.len");
        check("tp5.lenflag", bus.ERR_LEN, 1'b1);
        check("tp5.level", bus.LEVEL, 0);
        idle(1'b0);
        bus.ERR_CLR = 1;
        cycle("tp5.clr");
        check("tp5.cleared", bus.ERR_LEN, 1'b0);
        drive(1, 7'h33, 56'h1, 1, 31, 0, 0, 0, 1);
        cycle("tp5.setwins");
        idle(1'b0);
        bus.ERR_CLR = 1;
        cycle("tp5.clr2");

        // Flush beats a simultaneous push and pop.
        for (int i = 0; i < 3; i++) begin
            drive(1, 7'(8'h40 + i), 56'hABCD00 + 56'(i), 3, 2, 1, 0, 0, 0);
            cycle("tp6.fill");
        end
        drive(1, 7'h7F, 56'h55, 1, 0, 0, 1, 1, 0);
        cycle("tp6.flush");
        check("tp6.level", bus.LEVEL, 0);
        check("tp6.noerr", {bus.ERR_OVF, bus.ERR_LEN}, 2'b00);

        // Simultaneous push and pop at mid occupancy, and pop colliding with push when full.
        drive(1, 7'h11, 56'h1, 1, 0, 0, 0, 0, 0);
        cycle("mid.a");
        drive(1, 7'h12, 56'h2, 1, 0, 0, 1, 0, 0);
        cycle("mid.pushpop");
        drive(1, 7'h13, 56'h3, 2, 3, 0, 0, 0, 0);
        repeat (3) cycle("mid.fill");
        drive(1, 7'h14, 56'h4, 1, 0, 0, 1, 0, 0);
        cycle("mid.fullpop");
        idle(1'b0);
        bus.ERR_CLR = 1;
        cycle("mid.clr");

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 1), 7'($urandom), {$urandom, $urandom},
                  $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 30) == 0, $urandom_range(0, 15) == 0);
            cycle("rand");
        end

        // Asynchronous reset in the middle of a cycle empties the queue at once.
        drive(1, 7'h66, 56'h9, 1, 1, 1, 0, 0, 0);
        cycle("arst.fill");
        idle(1'b0);
        #5 RST_N = 1'b0;
        #1;
        check("arst.level", bus.LEVEL, 0);
        check("arst.valid", bus.CMD_VALID, 1'b0);
        check("arst.image", bus.DATA_FROM_CORE, 72'h0);
        mq.delete();
        m_ovf = 0; m_len = 0; m_tx = 0; m_drop = 0;
        check_all("arst");
        @(negedge CLK);
        RST_N = 1'b1;
        cycle("arst.after");

        // Narrow instance: NUM_TX above MAX_TX is refused, at-limit payload accepted.
        bus2.WR_EN = 1; bus2.SL_ADDR = 7'h11; bus2.NUM_TX = 3'd6; bus2.TX_DATA = 40'h5544332211;
        cycle("n.idle");
        check("n.len", bus2.ERR_LEN, 1'b1);
        check("n.level0", bus2.LEVEL, 0);
        bus2.NUM_TX = 3'd5;
        cycle("n.idle");
        check("n.level1", bus2.LEVEL, 1);
        check("n.image", bus2.DATA_FROM_CORE, {16'h0, 40'h5544332211, 8'h22});
        check("n.ntx", bus2.NUM_BYTES_TO_TRANSM_OUT, 5);
        cycle("n.idle");
        check("n.full", bus2.WR_FULL, 1'b1);
        cycle("n.idle");
        check("n.ovf", bus2.ERR_OVF, 1'b1);
        check("n.level2", bus2.LEVEL, 2);
        bus2.WR_EN = 0;
        cycle("n.idle");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
